mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 134 +++++++++++++
 tb/tb_mem_copy_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Byte-wise memory-to-memory copy engine. Each byte is read from the source
// region and then written to the destination region before the next read.
module mem_copy_engine #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              R,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_re,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A copy may cover the whole address space but no more.
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = 1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_inc;
    logic [DATA_W-1:0] byte_r;
    logic              err_r;
    logic              len_bad;
    logic              len_zero;

    assign count_inc = count_r + ONE;
    assign len_bad   = (len > MAX_LEN);
    assign len_zero  = (len == '0);

    always_ff @(posedge CLK) begin
        if (!R) begin
            state   <= IDLE;
            src_r   <= '0;
            dst_r   <= '0;
            len_r   <= '0;
            count_r <= '0;
            byte_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_r   <= src_addr;
                        dst_r   <= dst_addr;
                        len_r   <= len;
                        count_r <= '0;
                        err_r   <= len_bad;
                    end
                end
                READ: begin
                    byte_r <= mem_q;
                end
                WRITE: begin
                    count_r <= count_inc;
                end
                default: begin
                end
            endcase
        end
    end

    // All strobes and the bus are decoded from the registered state so they
    // are glitch-free with respect to start and the other inputs.
    always_comb begin
        state_next = state;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        mem_a      = '0;
        mem_d      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_bad || len_zero) begin
                        state_next = DONE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                mem_re     = 1'b1;
                busy       = 1'b1;
                mem_a      = src_r + count_r[ADDR_W-1:0];
                state_next = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                mem_a  = dst_r + count_r[ADDR_W-1:0];
                mem_d  = byte_r;
                if (count_inc < len_r) begin
                    state_next = READ;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign count = count_r;
    assign err   = err_r;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a reference copy on a shadow memory
// predicts each completion; a negedge monitor checks every done pulse.
module tb_mem_copy_engine;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int MEM_N  = 32;

    logic              CLK = 1'b0;
    logic              R;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] mem_q;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic              mem_re;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    mem_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .R(R), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .mem_q(mem_q), .mem_a(mem_a), .mem_d(mem_d), .mem_re(mem_re),
        .mem_we(mem_we), .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem     [MEM_N];
    logic [7:0] ref_mem [MEM_N];
    logic       pre_we;
    logic [4:0] pre_a;
    logic [7:0] pre_d;

    always @(posedge CLK) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (mem_we) mem[mem_a] <= mem_d;
    end
    assign mem_q = mem[mem_a];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;
    int acc        = 0;
    bit mon_en     = 1'b0;

    typedef struct {
        int           exp_cyc;
        int           exp_acc;
        logic [5:0]   exp_count;
        logic         exp_err;
        logic [255:0] exp_img;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [255:0] memImage();
        logic [255:0] img;
        for (int i = 0; i < MEM_N; i++) img[i*8 +: 8] = mem[i];
        return img;
    endfunction

    function automatic logic [255:0] refImage();
        logic [255:0] img;
        for (int i = 0; i < MEM_N; i++) img[i*8 +: 8] = ref_mem[i];
        return img;
    endfunction

    function automatic logic [5:0] pickLen();
        if ($urandom_range(0, 9) == 0) return 6'($urandom_range(33, 63));
        return 6'($urandom_range(0, 32));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkImage(input string name, input logic [255:0] actual, input logic [255:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: bus sanity every cycle, full scoreboard check on each done pulse.
    always @(negedge CLK) begin
        if (mon_en) begin
            acc = acc + int'(mem_re) + int'(mem_we);
            checkOutput("re_we_excl", 32'(mem_re & mem_we), 32'd0);
            assert (!(mem_re && mem_we)) else $error("[TB] mem_re and mem_we high together");
            checkOutput("busy_decode", 32'(busy), 32'(mem_re | mem_we));
            if (!busy) checkOutput("idle_bus", {17'd0, mem_re, mem_we, mem_a, mem_d}, 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("done_cycle", 32'(cyc), 32'(mon_e.exp_cyc));
                    checkOutput("done_count", 32'(count), 32'(mon_e.exp_count));
                    checkOutput("done_err", 32'(err), 32'(mon_e.exp_err));
                    checkOutput("done_busy", 32'(busy), 32'd0);
                    checkOutput("access_cnt", 32'(acc), 32'(mon_e.exp_acc));
                    checkImage("mem_image", memImage(), mon_e.exp_img);
                end
            end
        end
    end

    task automatic preloadByte(input int a, input logic [7:0] d);
        pre_we = 1'b1;
        pre_a  = 5'(a);
        pre_d  = d;
        ref_mem[a] = d;
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge CLK);
    endtask

    // Issues one copy at a negedge, predicts its outcome, optionally pokes
    // start again one cycle later (engine is then busy or in DONE).
    task automatic applyStimulus(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l, input bit disturb);
        exp_t e;
        int   eff;
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(posedge CLK);
        #1;
        if (int'(l) > MEM_N) begin
            e.exp_err   = 1'b1;
            e.exp_count = 6'd0;
            eff         = 0;
        end else begin
            for (int i = 0; i < int'(l); i++)
                ref_mem[(int'(d) + i) % MEM_N] = ref_mem[(int'(s) + i) % MEM_N];
            e.exp_err   = 1'b0;
            e.exp_count = l;
            eff         = int'(l);
        end
        e.exp_cyc = cyc + 2 * eff;
        e.exp_acc = acc + 2 * eff;
        e.exp_img = refImage();
        sb.push_back(e);
        @(negedge CLK);
        if (disturb) begin
            start    = 1'b1;
            src_addr = 5'($urandom);
            dst_addr = 5'($urandom);
            len      = pickLen();
        end else begin
            start = 1'b0;
        end
        @(negedge CLK);
        start    = 1'b0;
        src_addr = 5'($urandom);
        dst_addr = 5'($urandom);
        len      = pickLen();
        waitIdle();
    endtask

    task automatic resetMidCopy();
        src_addr = 5'd0;
        dst_addr = 5'd16;
        len      = 6'd4;
        start    = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("second_write", 32'(mem_we), 32'd1);
        R     = 1'b0;
        start = 1'b1;
        len   = 6'd0;
        @(negedge CLK);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        checkOutput("rst_bus", {19'd0, mem_a, mem_d}, 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        R     = 1'b1;
        start = 1'b0;
        ref_mem[16] = ref_mem[0];
        ref_mem[17] = ref_mem[1];
        repeat (4) @(negedge CLK);
        checkImage("rst_partial_copy", memImage(), refImage());
        checkOutput("rst_stays_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        R        = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        pre_we   = 1'b0;
        pre_a    = '0;
        pre_d    = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_bus", {17'd0, mem_re, mem_we, mem_a, mem_d}, 32'd0);
        R      = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < MEM_N; i++) preloadByte(i, 8'($urandom));

        preloadByte(0, 8'h11); preloadByte(1, 8'h22); preloadByte(2, 8'h33); preloadByte(3, 8'h44);
        applyStimulus(5'd0, 5'd8, 6'd4, 1'b0);
        checkOutput("basic_bytes", {mem[8], mem[9], mem[10], mem[11]}, 32'h11223344);
        checkOutput("basic_count_held", 32'(count), 32'd4);

        preloadByte(30, 8'hA1); preloadByte(31, 8'hA2); preloadByte(0, 8'hA3); preloadByte(1, 8'hA4);
        applyStimulus(5'd30, 5'd2, 6'd4, 1'b1);
        checkOutput("wrap_bytes", {mem[2], mem[3], mem[4], mem[5]}, 32'hA1A2A3A4);

        applyStimulus(5'd7, 5'd9, 6'd0, 1'b1);
        checkOutput("len0_count", 32'(count), 32'd0);
        applyStimulus(5'd7, 5'd9, 6'd33, 1'b0);
        checkOutput("err_held", 32'(err), 32'd1);
        checkOutput("err_count", 32'(count), 32'd0);
        applyStimulus(5'd4, 5'd20, 6'd32, 1'b1);
        checkOutput("err_cleared", 32'(err), 32'd0);

        preloadByte(0, 8'h05); preloadByte(1, 8'h06); preloadByte(2, 8'h07); preloadByte(3, 8'h08);
        applyStimulus(5'd0, 5'd1, 6'd3, 1'b0);
        checkOutput("overlap_bytes", {mem[0], mem[1], mem[2], mem[3]}, 32'h05050505);

        resetMidCopy();
        applyStimulus(5'd0, 5'd24, 6'd4, 1'b0);

        for (int n = 0; n < 40; n++)
            applyStimulus(5'($urandom), 5'($urandom), pickLen(), 1'($urandom_range(0, 1)));

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
